// File: rtl/detector_conditioner_pkg.sv
// Shared constants for the detector front-end: vector bit order and settle FSM encoding.
package detector_conditioner_pkg;

  localparam int unsigned DET_W = 4;

  // Bit positions inside the detector vector, matching the driving FSM.
  localparam int unsigned BACK  = 3;
  localparam int unsigned FRONT = 2;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 0;

  localparam int unsigned DB_CNT_W     = 8;
  localparam int unsigned SETTLE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    SETTLED = 2'b10
  } settle_state_t;

endpackage

// File: rtl/detector_conditioner_debounce_bit.sv
// One detector bit: two-flop synchroniser, mismatch run counter and filtered flop.
module detector_debounce_bit
  import detector_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_100hz,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic filt,
  output logic accept_c,
  output logic glitch_c
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE - 1);

  logic                sync_meta;
  logic                sync;
  logic [DB_CNT_W-1:0] cnt;
  logic                mismatch;

  assign mismatch = (sync != filt);

  // Accept on the DEBOUNCE-th consecutive mismatch; a run cut short is a glitch.
  assign accept_c = enable && mismatch && (cnt == DB_LAST);
  assign glitch_c = enable && !mismatch && (cnt != '0);

  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      filt      <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      if (!enable || !mismatch) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/detector_conditioner.sv
// Conditions the four raw obstacle detectors into a clean vector with change strobe,
// settled flag and a saturating glitch counter.
module detector_conditioner
  import detector_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk_100hz,
  input  logic             reset,
  input  logic             enable,
  input  logic             front_raw,
  input  logic             back_raw,
  input  logic             left_raw,
  input  logic             right_raw,
  output logic             front_detector,
  output logic             back_detector,
  output logic             left_detector,
  output logic             right_detector,
  output logic [DET_W-1:0] detectors,
  output logic             change_strobe,
  output logic             settled,
  output logic [CNT_W-1:0] glitch_count
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]        GC_MAX      = {CNT_W{1'b1}};

  logic [DET_W-1:0]        raw_vec;
  logic [DET_W-1:0]        filt_vec;
  logic [DET_W-1:0]        accept_vec;
  logic [DET_W-1:0]        glitch_vec;
  logic                    any_accept;
  logic                    any_glitch;
  settle_state_t           state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  assign raw_vec[BACK]  = back_raw;
  assign raw_vec[FRONT] = front_raw;
  assign raw_vec[LEFT]  = left_raw;
  assign raw_vec[RIGHT] = right_raw;

  for (genvar i = 0; i < DET_W; i++) begin : g_bit
    detector_debounce_bit #(
      .DEBOUNCE (DEBOUNCE)
    ) u_bit (
      .clk_100hz (clk_100hz),
      .reset     (reset),
      .enable    (enable),
      .raw       (raw_vec[i]),
      .filt      (filt_vec[i]),
      .accept_c  (accept_vec[i]),
      .glitch_c  (glitch_vec[i])
    );
  end

  assign any_accept = |accept_vec;
  assign any_glitch = |glitch_vec;

  assign detectors      = filt_vec;
  assign back_detector  = filt_vec[BACK];
  assign front_detector = filt_vec[FRONT];
  assign left_detector  = filt_vec[LEFT];
  assign right_detector = filt_vec[RIGHT];

  // Strobe and glitch counter; several simultaneous events count once.
  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      change_strobe <= 1'b0;
      glitch_count  <= '0;
    end else begin
      change_strobe <= any_accept;
      if (any_glitch && (glitch_count != GC_MAX)) begin
        glitch_count <= glitch_count + CNT_W'(1);
      end
    end
  end

  // Settle FSM: settled only after SETTLE accept-free enabled cycles.
  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= WAIT;
          settle_cnt <= '0;
          settled    <= 1'b0;
        end
        WAIT: begin
          if (any_accept) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= SETTLED;
            settle_cnt <= '0;
            settled    <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
          end
        end
        SETTLED: begin
          if (any_accept) begin
            state      <= WAIT;
            settle_cnt <= '0;
            settled    <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          settle_cnt <= '0;
          settled    <= 1'b0;
        end
      endcase
    end
  end

endmodule
